synapse_accumulator: RTL
========================

Name: synapse_accumulator

Overview:
Sits directly downstream of the spike router. Consumes routed weighted spike events (dest id, weight, exc/inh) and accumulates a signed input current per destination neuron for the current timestep. At each timestep tick it swaps double-buffered banks, then streams the finished per-neuron currents to the LIF neuron array while the next step accumulates.

Parameters:
NUM_NEURONS, 64, number of destination neurons (entries per bank)
NEURON_ID_WIDTH, $clog2(NUM_NEURONS), width of the neuron id
WEIGHT_WIDTH, 8, unsigned synaptic weight magnitude
ACC_WIDTH, 16, signed two's-complement accumulator width (must be > WEIGHT_WIDTH)

Ports:
clk  in  1  clock
rst_n  in  1  reset; synchronous, active-low
s_valid  in  1  routed spike event valid
s_dest_id  in  NEURON_ID_WIDTH  destination neuron
s_weight  in  WEIGHT_WIDTH  weight magnitude
s_exc_inh  in  1  1 = excitatory (add), 0 = inhibitory (subtract)
s_ready  out  1  event accept
timestep_tick  in  1  single-cycle pulse that closes the current timestep
m_valid  out  1  drained current valid
m_neuron_id  out  NEURON_ID_WIDTH  neuron id of the drained entry
m_current  out  ACC_WIDTH  signed accumulated current
m_ready  in  1  consumer accept
acc_busy  out  1  pipeline non-empty, tick pending, or drain active
sat_count  out  16  saturation events since reset; sticks at 0xFFFF
tick_overrun  out  1  sticky; a tick arrived while a tick was already pending

Behaviour:
- Reset: all accumulators in both banks = 0; active bank = 0; s_ready = 0 during reset and 1 from the first cycle after; m_valid = 0; m_neuron_id = 0; m_current = 0; sat_count = 0; tick_overrun = 0; acc_busy = 0. Reset mid-drain or mid-pipeline aborts all activity, with no partial output.
- Accept: event accepted when s_valid && s_ready. s_ready = !tick_pending.
- RMW pipeline, 2 stages:
  - S1 registers the event and reads acc[active][dest].
  - S2 computes sum = old + zext(weight) (exc) or old - zext(weight) (inh) in ACC_WIDTH+1 bits, clamps to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1], and writes back.
  - An event accepted in cycle N is visible in the bank at N+2.
  - Throughput is 1 event/cycle.
- Hazard: if S1 dest equals S2 dest, S1 uses the S2 result (forwarding). Back-to-back same-id events must sum exactly.
- Saturation: every clamp increments sat_count (saturating). The clamped value is written.
- Tick:
  - timestep_tick sets tick_pending.
  - An event accepted in the same cycle as the tick belongs to the closing step.
  - A tick while tick_pending = 1 sets tick_overrun and is otherwise ignored.
- Swap condition: tick_pending && pipeline empty && drain FSM in IDLE. On swap: active bank toggles, tick_pending clears, drain starts on the old bank.
- Drain FSM, states IDLE -> DRAIN -> IDLE:
  - In DRAIN, ids go 0..NUM_NEURONS-1 in order, presenting m_valid / m_neuron_id / m_current from registered outputs.
  - On an m_valid && m_ready handshake, that entry is cleared to 0 and the next id is presented on the following cycle. Rate is 1/cycle while m_ready = 1.
  - Outputs hold stable while m_valid && !m_ready.
  - After the handshake of the last id: m_valid = 0, return to IDLE.
- Concurrency: accumulation into the new active bank proceeds during drain. If a tick arrives while draining, s_ready = 0 until the drain completes and the swap occurs.
- acc_busy = S1 valid | S2 valid | tick_pending | (drain state != IDLE).

Optional Feature:
- SYNACC_SKIP_ZERO_EN defined: the drain does not present entries whose value is 0 (sparse output). The id scan advances one id per cycle past zero entries without asserting m_valid. An all-zero bank completes the drain in NUM_NEURONS cycles with no handshake.
- Undefined: every one of the NUM_NEURONS entries is presented, zeros included.

Test Plan:
- After reset: events (5,w=10,exc), (5,w=3,inh), (9,w=7,exc) on consecutive cycles, then tick with m_ready=1 -> drain emits 64 entries; id5=7, id9=7, others 0; sat_count=0.
- Hazard: 4 consecutive exc events to id 3 with w=255 -> id3=1020 after tick (forwarding correct, no lost update).
- Saturation: 200 exc events w=255 to id 0 (ACC_WIDTH=16) -> id0 = 32767; sat_count = number of clamped writes (72); inhibitory mirror clamps at -32768.
- Backpressure: m_ready toggled 1,0,0,1 during drain -> m_neuron_id/m_current stable while stalled; ids strictly 0..63; a second drain after the next tick shows all entries cleared.
- Overlap: tick while draining with m_ready=0 -> s_ready drops to 0; a second tick sets tick_overrun=1; after the drain completes the swap occurs, s_ready returns to 1, and events accepted during the drain appear in the next drain.
- Reset mid-drain at id 20 -> m_valid=0 next cycle; subsequent tick drains all zeros. With SYNACC_SKIP_ZERO_EN defined, events only to ids 2 and 40 -> exactly 2 handshakes.

Source files
------------

// File: rtl/synapse_accumulator.sv
// synapse_accumulator: double-buffered per-neuron current accumulator with RMW pipeline and drain FSM.
// Define SYNACC_SKIP_ZERO_EN to suppress zero-valued entries during drain.
module synapse_accumulator #(
  parameter int NUM_NEURONS     = 64,
  parameter int NEURON_ID_WIDTH = $clog2(NUM_NEURONS),
  parameter int WEIGHT_WIDTH    = 8,
  parameter int ACC_WIDTH       = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       s_valid,
  input  logic [NEURON_ID_WIDTH-1:0] s_dest_id,
  input  logic [WEIGHT_WIDTH-1:0]    s_weight,
  input  logic                       s_exc_inh,
  output logic                       s_ready,
  input  logic                       timestep_tick,
  output logic                       m_valid,
  output logic [NEURON_ID_WIDTH-1:0] m_neuron_id,
  output logic [ACC_WIDTH-1:0]       m_current,
  input  logic                       m_ready,
  output logic                       acc_busy,
  output logic [15:0]                sat_count,
  output logic                       tick_overrun
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;
  localparam logic [NEURON_ID_WIDTH:0] LAST = (NEURON_ID_WIDTH+1)'(NUM_NEURONS);
  logic [ACC_WIDTH-1:0] mem [2][NUM_NEURONS];
  logic [0:0] state;
  logic act, tick_pending;
  logic s1_v, s1_exc;
  logic [NEURON_ID_WIDTH-1:0] s1_id, rd_idx;
  logic [WEIGHT_WIDTH-1:0] s1_w;
  logic [ACC_WIDTH-1:0] s1_old, res, drain_val;
  logic [ACC_WIDTH:0] ext_w, sum;
  logic [NEURON_ID_WIDTH:0] idx;
  logic accept, swap, adv, load, finish, show, ovf, rd_bank;
  assign s_ready = rst_n && !tick_pending;
  assign accept = s_valid && s_ready;
  // Second pipeline stage: widened add/subtract, then clamp to the signed range.
  assign ext_w = {{(ACC_WIDTH+1-WEIGHT_WIDTH){1'b0}}, s1_w};
  assign sum = s1_exc ? {s1_old[ACC_WIDTH-1], s1_old} + ext_w : {s1_old[ACC_WIDTH-1], s1_old} - ext_w;
  assign ovf = sum[ACC_WIDTH] != sum[ACC_WIDTH-1];
  assign res = ovf ? {sum[ACC_WIDTH], {(ACC_WIDTH-1){~sum[ACC_WIDTH]}}} : sum[ACC_WIDTH-1:0];
  assign swap = tick_pending && !s1_v && state == IDLE;
  assign adv = !m_valid || m_ready;
  // The swap cycle itself loads entry 0 of the bank being retired.
  assign rd_bank = state == IDLE ? act : ~act;
  assign rd_idx = state == IDLE ? '0 : idx[NEURON_ID_WIDTH-1:0];
  assign drain_val = mem[rd_bank][rd_idx];
  assign load = swap || (state == DRAIN && adv && idx != LAST);
  assign finish = state == DRAIN && adv && idx == LAST;
  assign acc_busy = s1_v || tick_pending || state != IDLE;
`ifdef SYNACC_SKIP_ZERO_EN
  assign show = drain_val != '0;
`else
  assign show = 1'b1;
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < NUM_NEURONS; i++)
          mem[b][i] <= '0;
      state <= IDLE;
      act <= 1'b0;
      tick_pending <= 1'b0;
      tick_overrun <= 1'b0;
      s1_v <= 1'b0;
      s1_exc <= 1'b0;
      s1_id <= '0;
      s1_w <= '0;
      s1_old <= '0;
      idx <= '0;
      m_valid <= 1'b0;
      m_neuron_id <= '0;
      m_current <= '0;
      sat_count <= '0;
    end else begin
      if (s1_v) mem[act][s1_id] <= res;
      if (state == DRAIN && m_valid && m_ready) mem[~act][m_neuron_id] <= '0;
      if (s1_v && ovf && sat_count != 16'hFFFF) sat_count <= sat_count + 16'd1;
      s1_v <= accept;
      if (accept) begin
        s1_id <= s_dest_id;
        s1_w <= s_weight;
        s1_exc <= s_exc_inh;
        s1_old <= (s1_v && s1_id == s_dest_id) ? res : mem[act][s_dest_id];
      end
      if (timestep_tick && tick_pending) tick_overrun <= 1'b1;
      if (swap) tick_pending <= 1'b0;
      else if (timestep_tick) tick_pending <= 1'b1;
      if (swap) act <= ~act;
      if (load) begin
        state <= DRAIN;
        m_valid <= show;
        m_neuron_id <= rd_idx;
        m_current <= drain_val;
        idx <= {1'b0, rd_idx} + 1'b1;
      end else if (finish) begin
        state <= IDLE;
        m_valid <= 1'b0;
      end
    end
  end
endmodule
